// File: rtl/rx_hash_pkg.sv
// rx_hash_pkg: shared key width, FSM states and CRC fold helper for the rx MAC hash engine
package rx_hash_pkg;

    localparam int KEY_W = 60;

    typedef enum logic {IDLE, CALC} state_t;

    // Folds the top nb bits of bits (MSB first) into a cw-bit CRC; upper bits are masked off
    function automatic logic [15:0] crc_step(
        input logic [15:0]      crc,
        input logic [15:0]      poly,
        input logic [KEY_W-1:0] bits,
        input int               cw,
        input int               nb
    );
        logic [15:0]      c;
        logic [15:0]      m;
        logic [15:0]      top;
        logic [KEY_W-1:0] k;
        logic             fb;
        m   = 16'((17'(1) << cw) - 17'(1));
        top = 16'(17'(1) << (cw - 1));
        c   = crc & m;
        k   = bits;
        for (int i = 0; i < KEY_W; i++) begin
            if (i < nb) begin
                fb = ((c & top) != 16'h0) ^ k[KEY_W-1];
                c  = ((c << 1) ^ (fb ? poly : 16'h0)) & m;
                k  = k << 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_hash_req_fifo.sv
// rx_hash_req_fifo: register-array request FIFO with full/empty; a full FIFO accepts a push alongside a pop
module rx_hash_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 60
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          wr, rd;

    assign o_full  = cnt == (AW+1)'(DEPTH);
    assign o_empty = cnt == '0;
    assign wr      = i_push && (!o_full || i_pop);
    assign rd      = i_pop && !o_empty;
    assign o_data  = mem[rp];

    // Storage array; contents need no reset since the count gates every read
    always_ff @(posedge i_clk) begin
        if (wr) mem[wp] <= i_data;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wr ? wp + 1'b1 : wp;
            rp  <= rd ? rp + 1'b1 : rp;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

endmodule

// File: rtl/rx_mac_hash_engine.sv
// rx_mac_hash_engine: time-multiplexed CRC hash over {MAC, VLAN} for queued DMAC/SMAC lookups
module rx_mac_hash_engine
    import rx_hash_pkg::*;
#(
    parameter int          CWIDTH       = 15,
    parameter int          BITS_PER_CYC = 12,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] DEF_POLY     = 16'h4599,
    parameter logic [15:0] DEF_INIT     = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [15:0]       i_hash_poly_regs,
    input  logic [15:0]       i_hash_init_val_regs,
    input  logic              i_hash_regs_vld,
    input  logic [47:0]       i_dmac_data,
    input  logic [11:0]       i_dmac_vlan_id,
    input  logic              i_dmac_data_vld,
    input  logic [47:0]       i_smac_data,
    input  logic [11:0]       i_smac_vlan_id,
    input  logic              i_smac_data_vld,
    output logic              o_hash_vld,
    output logic              o_hash_is_smac,
    output logic [CWIDTH-1:0] o_hash_key,
    output logic [47:0]       o_mac,
    output logic [11:0]       o_vlan_id,
    output logic              o_busy,
    output logic [15:0]       o_drop_cnt
);
    localparam int N     = KEY_W / BITS_PER_CYC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t           state, state_nx;
    logic [KEY_W-1:0] d_q, s_q, sr, job_key;
    logic [15:0]      poly_sh, init_sh, poly_job, crc, crc_nx;
    logic [CNT_W-1:0] cnt;
    logic [16:0]      drop_sum;
    logic             d_full, d_empty, s_full, s_empty;
    logic             d_pop, s_pop, load, last, job_smac;

    assign d_pop    = state == IDLE && !d_empty;
    assign s_pop    = state == IDLE && d_empty && !s_empty;
    assign load     = d_pop || s_pop;
    assign last     = state == CALC && cnt == CNT_W'(N - 1);
    assign crc_nx   = crc_step(crc, poly_job, sr, CWIDTH, BITS_PER_CYC);
    assign o_busy   = state == CALC;
    assign drop_sum = {1'b0, o_drop_cnt}
                    + 17'(i_dmac_data_vld && d_full && !d_pop)
                    + 17'(i_smac_data_vld && s_full && !s_pop);

    rx_hash_req_fifo #(.DEPTH(FIFO_DEPTH), .W(KEY_W)) u_dmac_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_dmac_data_vld),
        .i_pop   (d_pop),
        .i_data  ({i_dmac_data, i_dmac_vlan_id}),
        .o_data  (d_q),
        .o_full  (d_full),
        .o_empty (d_empty)
    );

    rx_hash_req_fifo #(.DEPTH(FIFO_DEPTH), .W(KEY_W)) u_smac_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_smac_data_vld),
        .i_pop   (s_pop),
        .i_data  ({i_smac_data, i_smac_vlan_id}),
        .o_data  (s_q),
        .o_full  (s_full),
        .o_empty (s_empty)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state: leave IDLE on a pop, return after the last fold
    always_comb begin
        state_nx = (state == IDLE) ? (load ? CALC : IDLE) : (last ? IDLE : CALC);
    end

    // Shadow config; jobs latch their own copy at load so writes never disturb a running job
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            poly_sh <= DEF_POLY;
            init_sh <= DEF_INIT;
        end else if (i_hash_regs_vld) begin
            poly_sh <= i_hash_poly_regs;
            init_sh <= i_hash_init_val_regs;
        end
    end

    // Job load, per-cycle folding and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            crc            <= '0;
            poly_job       <= '0;
            sr             <= '0;
            job_key        <= '0;
            job_smac       <= 1'b0;
            cnt            <= '0;
            o_hash_vld     <= 1'b0;
            o_hash_is_smac <= 1'b0;
            o_hash_key     <= '0;
            o_mac          <= '0;
            o_vlan_id      <= '0;
        end else begin
            o_hash_vld <= last;
            if (load) begin
                crc      <= init_sh;
                poly_job <= poly_sh;
                sr       <= d_pop ? d_q : s_q;
                job_key  <= d_pop ? d_q : s_q;
                job_smac <= s_pop;
                cnt      <= '0;
            end else if (state == CALC) begin
                crc <= crc_nx;
                sr  <= sr << BITS_PER_CYC;
                cnt <= cnt + 1'b1;
            end
            if (last) begin
                o_hash_key     <= crc_nx[CWIDTH-1:0];
                o_hash_is_smac <= job_smac;
                o_mac          <= job_key[KEY_W-1:12];
                o_vlan_id      <= job_key[11:0];
            end
        end
    end

    // Saturating count of requests refused by a full FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_drop_cnt <= '0;
        else          o_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

endmodule

// File: tb/tb_rx_mac_hash_engine.sv
// tb_rx_mac_hash_engine: scoreboard bench for the rx MAC hash engine
module tb_rx_mac_hash_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] poly_r = '0, init_r = '0;
    logic        regs_vld = 1'b0;
    logic [47:0] dmac = '0, smac = '0;
    logic [11:0] dvlan = '0, svlan = '0;
    logic        dvld = 1'b0, svld = 1'b0;
    logic        hash_vld, is_smac, busy;
    logic [14:0] key;
    logic [47:0] mac;
    logic [11:0] vlan;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic        smac;
        logic [14:0] key;
        logic [47:0] mac;
        logic [11:0] vlan;
        int          cyc;
    } res_t;

    res_t got_q[$];
    res_t exp_q[$];

    rx_mac_hash_engine dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_hash_poly_regs     (poly_r),
        .i_hash_init_val_regs (init_r),
        .i_hash_regs_vld      (regs_vld),
        .i_dmac_data          (dmac),
        .i_dmac_vlan_id       (dvlan),
        .i_dmac_data_vld      (dvld),
        .i_smac_data          (smac),
        .i_smac_vlan_id       (svlan),
        .i_smac_data_vld      (svld),
        .o_hash_vld           (hash_vld),
        .o_hash_is_smac       (is_smac),
        .o_hash_key           (key),
        .o_mac                (mac),
        .o_vlan_id            (vlan),
        .o_busy               (busy),
        .o_drop_cnt           (drop_cnt)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (hash_vld) got_q.push_back('{is_smac, key, mac, vlan, cyc});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [14:0] model(input logic [15:0] p16, input logic [15:0] i16,
                                          input logic [47:0] m, input logic [11:0] v);
        logic [59:0] k;
        logic [14:0] c, p;
        logic        fb;
        k = {m, v};
        c = i16[14:0];
        p = p16[14:0];
        for (int i = 59; i >= 0; i--) begin
            fb = c[14] ^ k[i];
            c  = {c[13:0], 1'b0} ^ (fb ? p : 15'h0);
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_job(input logic s, input logic [14:0] k, input logic [47:0] m,
                              input logic [11:0] v, input int rel);
        exp_q.push_back('{s, k, m, v, rel});
    endtask

    task automatic sb_drain(input int t0, input int n);
        for (int j = 0; j < n; j++) begin
            int   w;
            res_t g, e;
            w = 0;
            while (got_q.size() == 0 && w < 200) begin
                tick();
                w++;
            end
            n_checks++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_timeout: no result, required key=%h", e.key);
            end else begin
                g = got_q.pop_front();
                if (g.key !== e.key || g.smac !== e.smac || g.mac !== e.mac || g.vlan !== e.vlan ||
                    (e.cyc >= 0 && g.cyc - t0 != e.cyc)) begin
                    n_fail++;
                    $display("FAIL sb_result: got smac=%0d key=%h mac=%h vlan=%h cyc=%0d, required smac=%0d key=%h mac=%h vlan=%h cyc=%0d",
                             g.smac, g.key, g.mac, g.vlan, g.cyc - t0, e.smac, e.key, e.mac, e.vlan, e.cyc);
                end
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({hash_vld, is_smac, busy, key, mac, vlan, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_in: outputs=%h required 0", {hash_vld, is_smac, busy, key, mac, vlan, drop_cnt});
        end
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if ({hash_vld, is_smac, busy, key, mac, vlan, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: outputs=%h required 0", {hash_vld, is_smac, busy, key, mac, vlan, drop_cnt});
        end
    endtask

    task automatic test_single();
        int t0;
        t0 = cyc; dmac = 48'h0; dvlan = 12'h001; dvld = 1'b1;
        expect_job(1'b0, 15'h4599, 48'h0, 12'h001, 7);
        tick(); dvld = 1'b0;
        sb_drain(t0, 1);
        tick();
        t0 = cyc; smac = 48'h0; svlan = 12'h002; svld = 1'b1;
        expect_job(1'b1, 15'h4EAB, 48'h0, 12'h002, 7);
        tick(); svld = 1'b0;
        sb_drain(t0, 1);
        tick();
        t0 = cyc; dmac = 48'h0; dvlan = 12'h000; dvld = 1'b1;
        expect_job(1'b0, 15'h0000, 48'h0, 12'h000, 7);
        tick(); dvld = 1'b0;
        sb_drain(t0, 1);
        tick();
        t0 = cyc; dmac = 48'hDEAD_BEEF_0123; dvlan = 12'hABC; dvld = 1'b1;
        expect_job(1'b0, model(16'h4599, 16'h0, 48'hDEAD_BEEF_0123, 12'hABC), 48'hDEAD_BEEF_0123, 12'hABC, 7);
        tick(); dvld = 1'b0;
        sb_drain(t0, 1);
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            smac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            svlan = 12'($urandom);
            svld = 1'b1;
            expect_job(1'b1, model(16'h4599, 16'h0, smac, svlan), smac, svlan, 7 + 6 * i);
            tick();
        end
        svld = 1'b0;
        sb_drain(t0, 3);
    endtask

    task automatic test_dual();
        int t0;
        logic eb;
        tick();
        t0 = cyc;
        dmac = 48'h1111_2222_3333; dvlan = 12'h044; dvld = 1'b1;
        smac = 48'h5555_6666_7777; svlan = 12'h088; svld = 1'b1;
        expect_job(1'b0, model(16'h4599, 16'h0, dmac, dvlan), dmac, dvlan, 7);
        expect_job(1'b1, model(16'h4599, 16'h0, smac, svlan), smac, svlan, 13);
        for (int k = 0; k <= 12; k++) begin
            if (k == 1) begin
                dvld = 1'b0;
                svld = 1'b0;
            end
            eb = !(k == 0 || k == 1 || k == 7);
            n_checks++;
            if (busy !== eb) begin
                n_fail++;
                $display("FAIL busy_cycle%0d: got %b required %b", k, busy, eb);
            end
            tick();
        end
        sb_drain(t0, 2);
    endtask

    task automatic test_drop();
        int t0;
        tick();
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            dmac = 48'h0000_0000_1000 + 48'(i);
            dvlan = 12'(i * 3 + 1);
            dvld = 1'b1;
            if (i != 5 && i != 6)
                expect_job(1'b0, model(16'h4599, 16'h0, dmac, dvlan), dmac, dvlan, -1);
            tick();
        end
        dvld = 1'b0;
        n_checks++;
        if (drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL drop_cnt: got %0d required 2", drop_cnt);
        end
        sb_drain(t0, 6);
    endtask

    task automatic test_config();
        int t0;
        tick();
        t0 = cyc;
        dmac = 48'hA5A5_0000_1234; dvlan = 12'h3C3; dvld = 1'b1;
        expect_job(1'b0, model(16'h4599, 16'h0000, dmac, dvlan), dmac, dvlan, 7);
        tick(); dvld = 1'b0;
        tick(); tick();
        poly_r = 16'h4599; init_r = 16'h7FFF; regs_vld = 1'b1;
        tick(); regs_vld = 1'b0;
        sb_drain(t0, 1);
        tick();
        t0 = cyc;
        smac = 48'h0102_0304_0506; svlan = 12'h7E1; svld = 1'b1;
        expect_job(1'b1, model(16'h4599, 16'h7FFF, smac, svlan), smac, svlan, 7);
        tick(); svld = 1'b0;
        sb_drain(t0, 1);
    endtask

    task automatic test_poly();
        int t0;
        poly_r = 16'h9021; init_r = 16'h0F0F; regs_vld = 1'b1;
        tick(); regs_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t0 = cyc;
            if (i[0]) begin
                smac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF; svlan = 12'($urandom); svld = 1'b1;
                expect_job(1'b1, model(16'h9021, 16'h0F0F, smac, svlan), smac, svlan, 7);
            end else begin
                dmac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF; dvlan = 12'($urandom); dvld = 1'b1;
                expect_job(1'b0, model(16'h9021, 16'h0F0F, dmac, dvlan), dmac, dvlan, 7);
            end
            tick(); dvld = 1'b0; svld = 1'b0;
            sb_drain(t0, 1);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        int busy_seen;
        dmac = 48'hCAFE_F00D_0001; dvlan = 12'h123; dvld = 1'b1;
        tick();
        dmac = 48'hCAFE_F00D_0002;
        tick(); dvld = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({hash_vld, is_smac, busy, key, mac, vlan, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs=%h required 0", {hash_vld, is_smac, busy, key, mac, vlan, drop_cnt});
        end
        tick(); tick();
        rst_n = 1'b1;
        busy_seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (busy) busy_seen++;
        end
        n_checks++;
        if (busy_seen != 0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_abort: busy cycles=%0d results=%0d required 0 and 0", busy_seen, got_q.size());
        end
        t0 = cyc; dmac = 48'h0; dvlan = 12'h001; dvld = 1'b1;
        expect_job(1'b0, 15'h4599, 48'h0, 12'h001, 7);
        tick(); dvld = 1'b0;
        sb_drain(t0, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_dual();
        test_drop();
        test_config();
        test_poly();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
